// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Build option: define MULDIV_FASTMUL_EN to replace the shift-add multiply with a single-cycle multiply.
module mips_muldiv_unit #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] hi,
  output logic [DATAWIDTH-1:0] lo,
  output logic                 divzero,
  output logic [2:0]           o_dbg_state
);

  localparam int CNTWIDTH = $clog2(DATAWIDTH) + 1;
  localparam int W2       = 2 * DATAWIDTH;
  localparam int MSB      = DATAWIDTH - 1;
`ifdef MULDIV_FASTMUL_EN
  localparam bit FASTMUL = 1'b1;
`else
  localparam bit FASTMUL = 1'b0;
`endif

  // Handshake: start is honoured only in IDLE (busy=0); an accepted MULT/DIV
  // raises busy on the accept edge and done pulses for one cycle when HI/LO update.
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [W2-1:0]         r_acc;
  logic [DATAWIDTH-1:0]  r_opa;
  logic [CNTWIDTH-1:0]   r_cnt;
  logic                  r_neg_q, r_neg_r, r_is_div;
  logic [DATAWIDTH-1:0]  r_hi, r_lo;
  logic                  r_busy, r_done, r_divzero;

  logic                  w_sgn, w_b_zero, w_last;
  logic [DATAWIDTH:0]    w_mul_sum, w_rem_sh, w_diff;
  logic [W2-1:0]         w_mul_next, w_div_next, w_prod, w_fixed;
  logic [DATAWIDTH-1:0]  w_q, w_r;

  function automatic logic [DATAWIDTH-1:0] f_neg(input logic [DATAWIDTH-1:0] x);
    return ~x + DATAWIDTH'(1);
  endfunction

  function automatic logic [DATAWIDTH-1:0] f_abs(input logic [DATAWIDTH-1:0] x);
    return x[MSB] ? f_neg(x) : x;
  endfunction

  assign w_sgn    = ~op[0];
  assign w_b_zero = (b == '0);
  assign w_last   = (r_cnt == CNTWIDTH'(DATAWIDTH - 1));

  // Multiply: accumulator holds {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[W2-1:DATAWIDTH]} + (r_acc[0] ? {1'b0, r_opa} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[DATAWIDTH-1:1]};

  // Divide: accumulator holds {remainder, dividend bits / quotient bits}.
  assign w_rem_sh   = r_acc[W2-1:DATAWIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opa};
  assign w_div_next = w_diff[DATAWIDTH]
                    ? {w_rem_sh[DATAWIDTH-1:0], r_acc[DATAWIDTH-2:0], 1'b0}
                    : {w_diff[DATAWIDTH-1:0],   r_acc[DATAWIDTH-2:0], 1'b1};

`ifdef MULDIV_FASTMUL_EN
  assign w_prod = {{DATAWIDTH{1'b0}}, r_opa} * {{DATAWIDTH{1'b0}}, r_acc[DATAWIDTH-1:0]};
`else
  assign w_prod = r_acc;
`endif

  assign w_q = r_acc[DATAWIDTH-1:0];
  assign w_r = r_acc[W2-1:DATAWIDTH];

  always_comb begin
    w_fixed = r_acc;
    if (!r_is_div)
      w_fixed = r_neg_q ? (~w_prod + W2'(1)) : w_prod;
    else if (r_divzero)
      w_fixed = {w_q, {DATAWIDTH{1'b1}}};  // low half holds the raw dividend here
    else
      w_fixed = {r_neg_r ? f_neg(w_r) : w_r, r_neg_q ? f_neg(w_q) : w_q};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001: w_state_nxt = FASTMUL ? S_FIX : S_MUL;
            3'b010, 3'b011: w_state_nxt = w_b_zero ? S_FIX : S_DIV;
            default:        w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_MUL, S_DIV: if (w_last) w_state_nxt = S_FIX;
      S_FIX:        w_state_nxt = S_DONE;
      S_DONE:       w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc     <= '0;
      r_opa     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_is_div  <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              3'b000, 3'b001: begin
                r_opa     <= w_sgn ? f_abs(a) : a;
                r_acc     <= {{DATAWIDTH{1'b0}}, (w_sgn ? f_abs(b) : b)};
                r_neg_q   <= w_sgn & (a[MSB] ^ b[MSB]);
                r_neg_r   <= 1'b0;
                r_is_div  <= 1'b0;
                r_divzero <= 1'b0;
                r_busy    <= 1'b1;
                r_cnt     <= '0;
              end
              3'b010, 3'b011: begin
                r_opa     <= w_sgn ? f_abs(b) : b;
                r_acc     <= {{DATAWIDTH{1'b0}}, (w_b_zero ? a : (w_sgn ? f_abs(a) : a))};
                r_neg_q   <= w_sgn & (a[MSB] ^ b[MSB]);
                r_neg_r   <= w_sgn & a[MSB];
                r_is_div  <= 1'b1;
                r_divzero <= w_b_zero;
                r_busy    <= 1'b1;
                r_cnt     <= '0;
              end
              3'b100: begin
                r_hi   <= a;
                r_done <= 1'b1;
              end
              3'b101: begin
                r_lo   <= a;
                r_done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CNTWIDTH'(1);
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + CNTWIDTH'(1);
        end
        S_FIX: r_acc <= w_fixed;
        S_DONE: begin
          r_hi   <= r_acc[W2-1:DATAWIDTH];
          r_lo   <= r_acc[DATAWIDTH-1:0];
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign divzero     = r_divzero;
  assign o_dbg_state = r_state;

endmodule
